// File: rtl/icache_fill.sv
// Direct-mapped instruction cache with a blocking line-refill FSM.
// Hits return data combinationally. A miss stalls fetch while the line is
// fetched one word per accepted beat, then commits the tag/valid bit.
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
module icache_fill #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SETS       = 16,
  parameter int unsigned WORDS      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  miss_stall,
  input  logic                  inv,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int unsigned WB   = $clog2(WORDS);
  localparam int unsigned IB   = $clog2(SETS);
  localparam int unsigned TLSB = 2 + WB + IB;
  localparam int unsigned TB   = DATA_WIDTH - TLSB;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_COMMIT} state_t;

  state_t                r_state;
  logic [WB-1:0]         r_beat;
  logic [TB-1:0]         r_ftag;
  logic [IB-1:0]         r_findex;
  logic [SETS-1:0]       r_valid;
  logic                  r_inv_pend;
  logic                  r_mem_req;
  logic [TB-1:0]         r_tag  [SETS];
  logic [DATA_WIDTH-1:0] r_data [SETS][WORDS];

  logic [WB-1:0] w_word;
  logic [IB-1:0] w_index;
  logic [TB-1:0] w_tag;
  logic          w_hit;
  logic          w_miss;
  logic [1:0]    w_unused_pc_lsb;

  // Address decode and lookup
  assign w_unused_pc_lsb = pc[1:0];
  assign w_word  = pc[2 +: WB];
  assign w_index = pc[2+WB +: IB];
  assign w_tag   = pc[TLSB +: TB];
  assign w_hit   = (r_state == S_IDLE) && r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_miss  = (r_state == S_IDLE) && !w_hit;

  assign instr      = r_data[w_index][w_word];
  assign miss_stall = !w_hit;
  assign mem_req    = r_mem_req;
  assign mem_addr   = {r_ftag, r_findex, r_beat, 2'b00};

  // Refill FSM, valid bits and invalidation tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_valid    <= '0;
      r_inv_pend <= 1'b0;
      r_mem_req  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_ftag    <= w_tag;
            r_findex  <= w_index;
            r_beat    <= '0;
            r_mem_req <= 1'b1;
            r_state   <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (inv) r_inv_pend <= 1'b1;
          if (mem_rvalid) begin
            r_beat <= r_beat + WB'(1);
            if (r_beat == WB'(WORDS - 1)) begin
              r_mem_req <= 1'b0;
              r_state   <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          r_inv_pend <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
      // An invalidate seen at any point of the refill keeps the line invalid
      if (r_state == S_COMMIT && !r_inv_pend && !inv) r_valid[r_findex] <= 1'b1;
      if (inv) r_valid <= '0;
    end
  end

  // Tag and data arrays: written only by the refill, never reset
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_REFILL && mem_rvalid) r_data[r_findex][r_beat] <= mem_rdata;
    if (!rst && r_state == S_COMMIT) r_tag[r_findex] <= r_ftag;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Hit/miss statistics, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit)  r_hit_count  <= r_hit_count + 32'd1;
      if (w_miss) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: doc/icache_fill.md
ICACHE_FILL -- requirements
Module: icache_fill

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of instruction words and addresses.
REQ-002 The block SHALL have parameter SETS, default 16, meaning the number of direct-mapped lines (power of 2).
REQ-003 The block SHALL have parameter WORDS, default 4, meaning the 32-bit words per line (power of 2, at least 2).
REQ-004 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port pc  input  DATA_WIDTH  fetch address from the fetch stage.
REQ-007 The block SHALL have port instr  output  DATA_WIDTH  instruction at pc, valid when miss_stall=0.
REQ-008 The block SHALL have port miss_stall  output  1  high while pc misses or a refill is in progress; ORed into StallF and StallD.
REQ-009 The block SHALL have port inv  input  1  single-cycle request to invalidate all lines.
REQ-010 The block SHALL have port mem_req  output  1  refill beat request to backing memory.
REQ-011 The block SHALL have port mem_addr  output  DATA_WIDTH  word address of the current beat.
REQ-012 The block SHALL have port mem_rvalid  input  1  backing memory returns mem_rdata this cycle.
REQ-013 The block SHALL have port mem_rdata  input  DATA_WIDTH  refill data.
REQ-014 The block SHALL have port hit_count  output  32  hit counter (see Configuration).
REQ-015 The block SHALL have port miss_count  output  32  miss counter (see Configuration).

Function
REQ-016 Address split SHALL be: pc[1:0] ignored; word = pc[2+:log2(WORDS)]; index = next log2(SETS) bits; tag = remaining upper bits.
REQ-017 A hit (valid[index] set and tag equal in IDLE) SHALL drive instr combinationally from the stored word with miss_stall=0, giving zero-cycle latency.
REQ-018 A miss in IDLE SHALL assert miss_stall combinationally in the same cycle; the FSM SHALL capture line base = {tag, index, zeros} and enter REFILL on the next edge.
REQ-019 The FSM SHALL have states IDLE, REFILL, and COMMIT, and SHALL recognise only IDLE→REFILL (on a miss), REFILL→COMMIT (on the last beat accepted), and COMMIT→IDLE (unconditionally).
REQ-020 In REFILL, the block SHALL drive mem_req=1 and mem_addr=base+4*beat; on each cycle with mem_rvalid=1 it SHALL write mem_rdata to word beat and increment beat; beat holds while mem_rvalid=0.
REQ-021 In COMMIT, the block SHALL set tag[index] and valid[index] and hold miss_stall=1, so the re-lookup in IDLE hits; minimum miss penalty is WORDS+2 cycles.
REQ-022 The block SHALL drive mem_req=0 in IDLE and COMMIT, and SHALL ignore mem_rvalid outside REFILL.
REQ-023 The block SHALL finish a refill to the captured base even if pc changes mid-refill (branch flush); afterwards it SHALL look up the new pc normally.
REQ-024 When inv=1 in IDLE, all valid bits SHALL clear on the next edge; when inv=1 in REFILL/COMMIT, the valid bits SHALL clear and the in-flight line SHALL NOT be marked valid at COMMIT.
REQ-025 If inv and a hit occur in the same cycle, instr SHALL still return the hit data that cycle.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, beat=0, all valid bits=0, mem_req=0, and hit_count=miss_count=0; tag and data arrays SHALL NOT be cleared.
REQ-027 A reset during REFILL SHALL abandon the refill, with mem_req low in the cycle after the edge and no line validated.

Configuration
REQ-028 With ICACHE_STATS_EN defined, hit_count SHALL increment once per IDLE cycle with a hit and miss_count once per IDLE→REFILL transition, both wrapping at 2^32.
REQ-029 Without ICACHE_STATS_EN, hit_count and miss_count SHALL be tied to 0 and no counter flops SHALL be synthesised.

Verification
REQ-030 After reset, pc=0x00000000 with memory returning 0x11,0x22,0x33,0x44 on consecutive cycles -> mem_addr 0x0,0x4,0x8,0xC; miss_stall high 6 cycles; then instr=0x11.
REQ-031 Next, pc=0x8 -> instr=0x33 with miss_stall=0 in the same cycle, and mem_req stays 0.
REQ-032 pc=0x100 (same index, different tag) -> miss, refill from 0x100, and the line at 0x0 is evicted, so pc=0x0 misses again.
REQ-033 mem_rvalid gapped 1-0-0-1-1-0-1 -> 4 words written in order and beat held during gaps; stall length 9 cycles.
REQ-034 inv pulsed during the second refill beat -> refill completes, pc still misses after COMMIT, and a new refill starts.
REQ-035 rst asserted during the third beat -> mem_req=0 the next cycle, and the same pc misses again; with ICACHE_STATS_EN, miss_count=1 after the re-miss.
